// File: rtl/pool_fmap_serializer_pkg.sv
// Shared constants and types for the pooled feature-map serializer.
// Frame geometry defaults and FSM state encoding live here.
package pool_fmap_serializer_pkg;

    localparam int CI         = 3;
    localparam int POOL_OH    = 4;
    localparam int POOL_OW    = 4;
    localparam int PIX_DW     = 32;
    localparam int DROP_W     = 8;
    localparam int N_POOL_PIX = CI * POOL_OH * POOL_OW;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_e;

endpackage

// File: rtl/pool_fmap_serializer.sv
// Captures one pooled frame on a strobe and streams it out one pixel per
// valid/ready beat; strobes arriving while busy are dropped and counted.
module pool_fmap_serializer
    import pool_fmap_serializer_pkg::*;
#(
    parameter int P_CI     = CI,
    parameter int P_OH     = POOL_OH,
    parameter int P_OW     = POOL_OW,
    parameter int P_DW     = PIX_DW,
    parameter int P_DROP_W = DROP_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_in_valid,
    input  logic [P_CI*P_OH*P_OW*P_DW-1:0] i_in_fmap,
    output logic                          o_in_ready,
    output logic                          o_ot_valid,
    input  logic                          i_ot_ready,
    output logic [P_DW-1:0]               o_ot_data,
    output logic [1:0]                    o_ot_ch,
    output logic [1:0]                    o_ot_row,
    output logic [1:0]                    o_ot_col,
    output logic                          o_ot_last,
    output logic                          o_drop,
    output logic [P_DROP_W-1:0]           o_drop_cnt
);

    localparam int N  = P_CI * P_OH * P_OW;
    localparam int FW = N * P_DW;
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0]       CNT_LAST = CW'(N - 1);
    localparam logic [P_DROP_W-1:0] DROP_MAX = '1;

    ser_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [FW-1:0]       buf_q, buf_d;
    logic                drop_q, drop_d;
    logic [P_DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic          streaming;
    logic          hs;
    logic          at_last;
    logic [CW-1:0] ch_full;

    assign streaming = (state_q == STREAM);
    assign hs        = streaming & i_ot_ready;
    assign at_last   = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        drop_d     = 1'b0;
        drop_cnt_d = drop_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_in_valid) begin
                    buf_d   = i_in_fmap;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // Includes a strobe coinciding with the final handshake.
                if (i_in_valid) begin
                    drop_d = 1'b1;
                    if (drop_cnt_q != DROP_MAX) begin
                        drop_cnt_d = drop_cnt_q + 1'b1;
                    end
                end
                if (hs) begin
                    if (at_last) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_q      <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Index fields are a plain split of cnt: {ch, row[1:0], col[1:0]}.
    assign ch_full    = cnt_q >> 4;
    assign o_ot_ch    = ch_full[1:0];
    assign o_ot_row   = cnt_q[3:2];
    assign o_ot_col   = cnt_q[1:0];
    assign o_in_ready = ~streaming;
    assign o_ot_valid = streaming;
    assign o_ot_data  = streaming ? buf_q[P_DW*cnt_q +: P_DW] : '0;
    assign o_ot_last  = streaming & at_last;
    assign o_drop     = drop_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule
